// File: rtl/apb2axi_issue_queue.sv
// -----------------------------------------------------------------------------
// apb2axi_issue_queue
//
// Buffers committed transfer descriptors (tag, addr, len, size, direction) in
// a FIFO. Each descriptor is issued as one AXI address-channel request: AR for
// reads, AW for writes. Issue is strictly in FIFO order. It is throttled by a
// count of issued-but-unretired requests, and the response path retires that
// count through cpl_pulse.
//
// Ports:
//   pclk, preset             clock, asynchronous active-high reset
//   in_valid/in_ready        descriptor push handshake
//   in_tag/in_addr/in_len/
//   in_size/in_is_write      descriptor fields
//   ar*/aw*                  AXI read/write address channels (burst is INCR)
//   cpl_pulse                one request retired this cycle
//   fifo_count               entries currently held in the FIFO
//   outstanding              issued-but-unretired request count
//   err_underflow            sticky: cpl_pulse seen while outstanding == 0
// -----------------------------------------------------------------------------
module apb2axi_issue_queue #(
    parameter int FIFO_DEPTH      = 8,
    parameter int TAG_W_P         = 4,
    parameter int ADDR_W_P        = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 pclk,
    input  logic                                 preset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [TAG_W_P-1:0]                   in_tag,
    input  logic [ADDR_W_P-1:0]                  in_addr,
    input  logic [7:0]                           in_len,
    input  logic [2:0]                           in_size,
    input  logic                                 in_is_write,
    output logic                                 arvalid,
    input  logic                                 arready,
    output logic [TAG_W_P-1:0]                   arid,
    output logic [ADDR_W_P-1:0]                  araddr,
    output logic [7:0]                           arlen,
    output logic [2:0]                           arsize,
    output logic [1:0]                           arburst,
    output logic                                 awvalid,
    input  logic                                 awready,
    output logic [TAG_W_P-1:0]                   awid,
    output logic [ADDR_W_P-1:0]                  awaddr,
    output logic [7:0]                           awlen,
    output logic [2:0]                           awsize,
    output logic [1:0]                           awburst,
    input  logic                                 cpl_pulse,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_underflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    // Descriptor packing: {is_write, size, len, addr, tag}
    localparam int ADDR_LO = TAG_W_P;
    localparam int LEN_LO  = TAG_W_P + ADDR_W_P;
    localparam int SIZE_LO = LEN_LO + 8;
    localparam int DESC_W  = SIZE_LO + 3 + 1;
    localparam int HOLD_W  = DESC_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_AR = 2'd1,
        ST_ISSUE_AW = 2'd2
    } state_t;

    logic [DESC_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_r;
    logic [PTR_W:0]    rd_ptr_r;
    logic [CNT_W-1:0]  count_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [DESC_W-1:0] in_desc_s;
    logic [DESC_W-1:0] head_s;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [HOLD_W-1:0] hold_r;
    logic [1:0]        burst_r;
    logic              arvalid_r;
    logic              awvalid_r;
    logic              arvalid_nxt_s;
    logic              awvalid_nxt_s;
    logic              ar_hs_s;
    logic              aw_hs_s;
    logic              hs_s;

    logic [OUT_W-1:0]  out_r;
    logic              err_r;

    // FIFO occupancy from wrap-bit pointers; full/empty are exact
    assign count_s   = wr_ptr_r - rd_ptr_r;
    assign full_s    = (count_s == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_s == {CNT_W{1'b0}});
    // Based on registered occupancy only, so a same-cycle pop never frees a full FIFO
    assign in_ready  = ~preset & ~full_s;
    assign push_s    = in_valid & in_ready;
    assign in_desc_s = {in_is_write, in_size, in_len, in_addr, in_tag};
    assign head_s    = mem_r[rd_ptr_r[PTR_W-1:0]];

    assign ar_hs_s   = arvalid_r & arready;
    assign aw_hs_s   = awvalid_r & awready;
    assign hs_s      = ar_hs_s | aw_hs_s;

    // Descriptor storage; contents need no reset since occupancy is pointer-tracked
    always_ff @(posedge pclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= in_desc_s;
        end
    end

    // FIFO read/write pointers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Pop decision: only from IDLE, with data available and issue credit left
    always_comb begin
        if ((state_r == ST_IDLE) && !empty_s && (out_r < OUT_W'(MAX_OUTSTANDING))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = head_s[DESC_W-1] ? ST_ISSUE_AW : ST_ISSUE_AR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE_AR: begin
                if (ar_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ISSUE_AR;
                end
            end
            ST_ISSUE_AW: begin
                if (aw_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ISSUE_AW;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: next value of the registered valid flags
    always_comb begin
        arvalid_nxt_s = 1'b0;
        awvalid_nxt_s = 1'b0;
        case (state_r)
            ST_ISSUE_AR: arvalid_nxt_s = ~ar_hs_s;
            ST_ISSUE_AW: awvalid_nxt_s = ~aw_hs_s;
            default: begin
                arvalid_nxt_s = 1'b0;
                awvalid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered valids; they depend on state and handshake history, never on ready this cycle
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            arvalid_r <= 1'b0;
            awvalid_r <= 1'b0;
        end else begin
            arvalid_r <= arvalid_nxt_s;
            awvalid_r <= awvalid_nxt_s;
        end
    end

    // Holding register; only reloaded from IDLE, so payload is frozen while valid is up
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            hold_r  <= {HOLD_W{1'b0}};
            burst_r <= 2'b00;
        end else if (pop_s) begin
            hold_r  <= head_s[HOLD_W-1:0];
            burst_r <= 2'b01;
        end
    end

    // Issued-but-unretired counter; a simultaneous issue and retire cancel out
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            out_r <= {OUT_W{1'b0}};
        end else begin
            case ({hs_s, cpl_pulse})
                2'b10: out_r <= out_r + {{(OUT_W-1){1'b0}}, 1'b1};
                2'b01: begin
                    if (out_r != {OUT_W{1'b0}}) begin
                        out_r <= out_r - {{(OUT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: out_r <= out_r;
            endcase
        end
    end

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            err_r <= 1'b0;
        end else if (cpl_pulse && (out_r == {OUT_W{1'b0}})) begin
            err_r <= 1'b1;
        end
    end

    assign arvalid       = arvalid_r;
    assign arid          = hold_r[TAG_W_P-1:0];
    assign araddr        = hold_r[ADDR_LO +: ADDR_W_P];
    assign arlen         = hold_r[LEN_LO +: 8];
    assign arsize        = hold_r[SIZE_LO +: 3];
    assign arburst       = burst_r;
    assign awvalid       = awvalid_r;
    assign awid          = hold_r[TAG_W_P-1:0];
    assign awaddr        = hold_r[ADDR_LO +: ADDR_W_P];
    assign awlen         = hold_r[LEN_LO +: 8];
    assign awsize        = hold_r[SIZE_LO +: 3];
    assign awburst       = burst_r;
    assign fifo_count    = count_s;
    assign outstanding   = out_r;
    assign err_underflow = err_r;

endmodule
